// File: rtl/regfile_rename.sv
// Architectural register file with ROB rename tags.
// Commit/issue/rollback update state; two zero-latency operand queries.
module regfile_rename #(
  parameter int REG_NUM   = 32,
  parameter int REG_POS_W = 5,
  parameter int DATA_W    = 32,
  parameter int ROB_POS_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 issue,
  input  logic [REG_POS_W-1:0] issue_rd,
  input  logic [ROB_POS_W-1:0] issue_rob_pos,
  input  logic                 reg_write,
  input  logic [REG_POS_W-1:0] reg_rd,
  input  logic [DATA_W-1:0]    reg_val,
  input  logic [ROB_POS_W-1:0] commit_rob_pos,
  input  logic [REG_POS_W-1:0] rs1_pos,
  output logic                 rs1_busy,
  output logic [DATA_W-1:0]    rs1_val,
  output logic [ROB_POS_W-1:0] rs1_rob_pos,
  input  logic [REG_POS_W-1:0] rs2_pos,
  output logic                 rs2_busy,
  output logic [DATA_W-1:0]    rs2_val,
  output logic [ROB_POS_W-1:0] rs2_rob_pos
);

  logic [DATA_W-1:0]    val_q [REG_NUM];
  logic [ROB_POS_W-1:0] tag_q [REG_NUM];
  logic [REG_NUM-1:0]   busy_q;

  logic commit_en;
  logic issue_en;

  assign commit_en = reg_write && (reg_rd != '0);
  assign issue_en  = issue && (issue_rd != '0);

  // Later assignments win: issue overrides the
  // commit clear, rollback overrides everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
      busy_q <= '0;
    end else if (rdy) begin
      if (commit_en) begin
        val_q[reg_rd] <= reg_val;
        if (busy_q[reg_rd] &&
            tag_q[reg_rd] == commit_rob_pos)
          busy_q[reg_rd] <= 1'b0;
      end
      if (issue_en) begin
        busy_q[issue_rd] <= 1'b1;
        tag_q[issue_rd]  <= issue_rob_pos;
      end
      if (rollback)
        busy_q <= '0;
    end
  end

  logic [REG_POS_W-1:0] q_pos  [2];
  logic                 q_busy [2];
  logic [DATA_W-1:0]    q_val  [2];
  logic [ROB_POS_W-1:0] q_rob  [2];

  assign q_pos[0]    = rs1_pos;
  assign q_pos[1]    = rs2_pos;
  assign rs1_busy    = q_busy[0];
  assign rs1_val     = q_val[0];
  assign rs1_rob_pos = q_rob[0];
  assign rs2_busy    = q_busy[1];
  assign rs2_val     = q_val[1];
  assign rs2_rob_pos = q_rob[1];

  for (genvar g = 0; g < 2; g++) begin : g_query
    logic hit;

    // Forward a commit that retires the pending
    // producer of this register in the same cycle.
    assign hit = reg_write &&
                 reg_rd == q_pos[g] &&
                 q_pos[g] != '0 &&
                 busy_q[q_pos[g]] &&
                 tag_q[q_pos[g]] == commit_rob_pos;

    always_comb begin
      q_busy[g] = busy_q[q_pos[g]];
      q_val[g]  = val_q[q_pos[g]];
      q_rob[g]  = tag_q[q_pos[g]];
      if (q_pos[g] == '0) begin
        q_busy[g] = 1'b0;
        q_val[g]  = '0;
      end else if (hit) begin
        q_busy[g] = 1'b0;
        q_val[g]  = reg_val;
      end
    end
  end

endmodule

// File: tb/tb_regfile_rename.sv
// Scoreboard bench for regfile_rename.
// Stimulus queues expectations; monitor checks at negedge.
module tb_regfile_rename;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        rollback;
  logic        issue;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_rob_pos;
  logic        reg_write;
  logic [4:0]  reg_rd;
  logic [31:0] reg_val;
  logic [3:0]  commit_rob_pos;
  logic [4:0]  rs1_pos;
  logic        rs1_busy;
  logic [31:0] rs1_val;
  logic [3:0]  rs1_rob_pos;
  logic [4:0]  rs2_pos;
  logic        rs2_busy;
  logic [31:0] rs2_val;
  logic [3:0]  rs2_rob_pos;

  regfile_rename dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .rollback       (rollback),
    .issue          (issue),
    .issue_rd       (issue_rd),
    .issue_rob_pos  (issue_rob_pos),
    .reg_write      (reg_write),
    .reg_rd         (reg_rd),
    .reg_val        (reg_val),
    .commit_rob_pos (commit_rob_pos),
    .rs1_pos        (rs1_pos),
    .rs1_busy       (rs1_busy),
    .rs1_val        (rs1_val),
    .rs1_rob_pos    (rs1_rob_pos),
    .rs2_pos        (rs2_pos),
    .rs2_busy       (rs2_busy),
    .rs2_val        (rs2_val),
    .rs2_rob_pos    (rs2_rob_pos)
  );

  typedef struct {
    int          port;
    logic        busy;
    logic [31:0] val;
    logic [3:0]  rob;
    bit          cv;
    bit          cr;
  } exp_t;

  exp_t  sb_q [$];
  string nm_q [$];
  int    checks = 0;
  int    errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_q(
    input int          port,
    input logic        busy,
    input logic [31:0] val,
    input logic [3:0]  rob,
    input bit          cv,
    input bit          cr,
    input string       name
  );
    exp_t e;
    e.port = port;
    e.busy = busy;
    e.val  = val;
    e.rob  = rob;
    e.cv   = cv;
    e.cr   = cr;
    sb_q.push_back(e);
    nm_q.push_back(name);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    rdy       = 1'b1;
    rollback  = 1'b0;
    issue     = 1'b0;
    reg_write = 1'b0;
  endtask

  task automatic do_issue(
    input logic [4:0] rd,
    input logic [3:0] slot
  );
    issue         = 1'b1;
    issue_rd      = rd;
    issue_rob_pos = slot;
  endtask

  task automatic do_commit(
    input logic [4:0]  rd,
    input logic [3:0]  slot,
    input logic [31:0] v
  );
    reg_write      = 1'b1;
    reg_rd         = rd;
    commit_rob_pos = slot;
    reg_val        = v;
  endtask

  // Monitor: outputs are always presented, so
  // every queued expectation is due at negedge.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t        e;
      string       n;
      logic        gb;
      logic [31:0] gv;
      logic [3:0]  gr;
      bit          bad;
      e  = sb_q.pop_front();
      n  = nm_q.pop_front();
      gb = e.port == 0 ? rs1_busy : rs2_busy;
      gv = e.port == 0 ? rs1_val : rs2_val;
      gr = e.port == 0 ? rs1_rob_pos : rs2_rob_pos;
      bad = gb !== e.busy;
      if (e.cv && gv !== e.val) bad = 1'b1;
      if (e.cr && gr !== e.rob) bad = 1'b1;
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s: got busy=%0b val=%h rob=%0d, want busy=%0b val=%h rob=%0d",
                 n, gb, gv, gr, e.busy, e.val, e.rob);
      end
    end
  end

  initial begin
    rst            = 1'b0;
    rdy            = 1'b1;
    rollback       = 1'b0;
    issue          = 1'b0;
    issue_rd       = '0;
    issue_rob_pos  = '0;
    reg_write      = 1'b0;
    reg_rd         = '0;
    reg_val        = '0;
    commit_rob_pos = '0;
    rs1_pos        = '0;
    rs2_pos        = '0;

    // reset held; issue must be ignored
    cyc();
    do_issue(5, 9);
    rs1_pos = 5;
    rs2_pos = 0;
    expect_q(0, 0, 0, 0, 1, 0, "rst_rs1");
    expect_q(1, 0, 0, 0, 1, 0, "rst_rs2");

    cyc();
    rst = 1'b1;
    do_issue(5, 3);
    expect_q(0, 0, 0, 0, 1, 0, "post_rst");

    cyc();
    expect_q(0, 1, 0, 3, 0, 1, "issue5");

    cyc();
    do_commit(5, 3, 32'hDEADBEEF);
    rs2_pos = 5;
    expect_q(0, 0, 32'hDEADBEEF, 0, 1, 0, "byp1");
    expect_q(1, 0, 32'hDEADBEEF, 0, 1, 0, "byp2");

    cyc();
    rs2_pos = 0;
    expect_q(0, 0, 32'hDEADBEEF, 0, 1, 0, "stored5");

    cyc();
    do_issue(7, 2);
    rs1_pos = 7;
    cyc();
    do_issue(7, 6);
    expect_q(0, 1, 0, 2, 0, 1, "r7_t2");
    cyc();
    do_commit(7, 2, 32'h11);
    expect_q(0, 1, 0, 6, 0, 1, "r7_nobyp");
    cyc();
    expect_q(0, 1, 32'h11, 6, 1, 1, "r7_old");
    cyc();
    do_commit(7, 6, 32'h22);
    expect_q(0, 0, 32'h22, 0, 1, 0, "r7_byp");
    cyc();
    expect_q(0, 0, 32'h22, 0, 1, 0, "r7_done");

    cyc();
    do_issue(9, 4);
    rs1_pos = 9;
    cyc();
    do_commit(9, 4, 32'hA5A5);
    do_issue(9, 8);
    expect_q(0, 0, 32'hA5A5, 0, 1, 0, "r9_byp");
    cyc();
    expect_q(0, 1, 32'hA5A5, 8, 1, 1, "r9_issue");

    cyc();
    do_commit(1, 0, 32'h101);
    cyc();
    do_commit(2, 0, 32'h202);
    do_issue(1, 1);
    cyc();
    do_issue(2, 2);
    cyc();
    do_issue(3, 3);
    rs1_pos = 1;
    rs2_pos = 2;
    expect_q(0, 1, 32'h101, 1, 1, 1, "r1_busy");
    expect_q(1, 1, 32'h202, 2, 1, 1, "r2_busy");
    cyc();
    rollback = 1'b1;
    do_issue(4, 5);
    rs1_pos = 3;
    expect_q(0, 1, 0, 3, 0, 1, "r3_busy");
    cyc();
    rs1_pos = 1;
    expect_q(0, 0, 32'h101, 0, 1, 0, "rb_r1");
    expect_q(1, 0, 32'h202, 0, 1, 0, "rb_r2");
    cyc();
    rs1_pos = 3;
    rs2_pos = 4;
    expect_q(0, 0, 0, 0, 1, 0, "rb_r3");
    expect_q(1, 0, 0, 0, 1, 0, "rb_r4");
    cyc();
    rs1_pos = 9;
    expect_q(0, 0, 32'hA5A5, 0, 1, 0, "rb_r9");

    cyc();
    do_issue(0, 7);
    do_commit(0, 7, 32'h55);
    rs1_pos = 0;
    expect_q(0, 0, 0, 0, 1, 0, "x0_cyc");
    cyc();
    rs2_pos = 0;
    expect_q(0, 0, 0, 0, 1, 0, "x0_a");
    expect_q(1, 0, 0, 0, 1, 0, "x0_b");

    cyc();
    rdy = 1'b0;
    do_issue(10, 1);
    do_commit(10, 1, 32'h77);
    rs1_pos = 10;
    expect_q(0, 0, 0, 0, 1, 0, "rdy0_cyc");
    cyc();
    expect_q(0, 0, 0, 0, 1, 0, "rdy0_hold");

    cyc();
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d left, want 0",
               sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_rename.md
Name: regfile_rename

Overview:
- Architectural register file with per-register rename tags.
- Sits directly downstream of the reorder buffer's commit port: takes committed register writes and the rollback flush from it.
- Also sits beside the decoder/issue stage: records the destination ROB slot of each newly issued instruction.
- Answers decoder operand queries with a value, or with the ROB slot that will produce the value; committed results are bypassed in the same cycle.

Parameters:
- REG_NUM, 32, number of architectural registers
- REG_POS_W, 5, register index width
- DATA_W, 32, data width
- ROB_POS_W, 4, ROB slot index width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; no state change when low
- rollback  in  1  ROB flush after a mispredict
- issue  in  1  an instruction is issued this cycle
- issue_rd  in  REG_POS_W  destination register of the issued instruction
- issue_rob_pos  in  ROB_POS_W  ROB slot allocated to the issued instruction
- reg_write  in  1  ROB commit writes a register
- reg_rd  in  REG_POS_W  commit destination register
- reg_val  in  DATA_W  commit value
- commit_rob_pos  in  ROB_POS_W  ROB slot being committed
- rs1_pos  in  REG_POS_W  query 1 register index
- rs1_busy  out  1  query 1 value pending in the ROB
- rs1_val  out  DATA_W  query 1 value; valid when not busy
- rs1_rob_pos  out  ROB_POS_W  query 1 producing slot; valid when busy
- rs2_pos, rs2_busy, rs2_val, rs2_rob_pos  same as the rs1 ports, for query 2

Behaviour:
- State per register: val[DATA_W], busy[1], tag[ROB_POS_W].
- Reset (rst low, asynchronous): all val = 0, busy = 0, tag = 0.
  - Outputs are combinational, so during reset every query returns busy = 0 and val = 0.
- rdy low: state frozen; outputs still track current state.
- Register x0:
  - Never written; val stays 0.
  - Never marked busy.
  - Issue or commit with rd = 0 is ignored.
- Commit (rdy, reg_write, reg_rd != 0), at the rising edge:
  - val[reg_rd] <= reg_val, unconditionally. Commits arrive in program order, so the latest commit is architectural.
  - busy[reg_rd] <= 0 only if busy[reg_rd] and tag[reg_rd] == commit_rob_pos. Otherwise a newer producer is still pending and busy/tag are kept.
- Issue (rdy, issue, issue_rd != 0), at the rising edge:
  - busy[issue_rd] <= 1.
  - tag[issue_rd] <= issue_rob_pos.
- Same-cycle issue and commit to the same rd:
  - Issue wins for busy/tag: ends busy = 1, tag = issue_rob_pos.
  - The val write still happens.
- Rollback (rdy, rollback):
  - All busy <= 0. Tags may be left stale.
  - Rollback overrides any same-cycle issue: no register ends busy.
  - A same-cycle commit val write is still performed.
- Query (rsX, combinational, zero latency):
  - Default: busy = busy[pos], val = val[pos], rob_pos = tag[pos].
  - Bypass: if reg_write && reg_rd == pos && pos != 0 && busy[pos] && tag[pos] == commit_rob_pos, then report busy = 0 and val = reg_val.
  - The bypass does not consider a same-cycle issue. Issue logic reads operands before its own destination update.
  - pos = 0 always returns busy = 0, val = 0.
- Both query ports are independent and may address the same register.
- Tag wrap-around: slot numbers are reused after the ROB wraps. The tag equality check guards this, because a slot is not reallocated until it has committed.

Test Plan:
- Reset, then query rs1 = 5 and rs2 = 0 -> both busy = 0, val = 0; release reset, issue rd = 5 at slot 3 -> rs1 busy = 1, rob_pos = 3.
- Rd = 5 busy with tag 3; commit reg_write, rd = 5, slot 3, val 0xDEADBEEF -> same cycle rs1 busy = 0, val = 0xDEADBEEF (bypass); next cycle stored, busy = 0.
- Issue rd = 7 at slot 2, then rd = 7 at slot 6; commit slot 2 with val 0x11 -> val[7] = 0x11 but busy = 1, tag = 6; commit slot 6 with 0x22 -> busy = 0, val = 0x22.
- Same cycle: commit rd = 9 slot 4 (tag 4) and issue rd = 9 slot 8 -> val[9] = commit value, busy = 1, tag = 8.
- Registers 1, 2, 3 busy; assert rollback together with an issue to rd = 4 -> all busy = 0, including rd 4; values unchanged.
- Issue rd = 0 and commit rd = 0 with val 0x55 -> query 0 returns busy = 0, val = 0; hold rdy low during an issue to rd = 10 -> rd 10 stays not busy.
